// File: rtl/qubit_frame_collector_pkg.sv
// Shared types and constants for the qubit frame collector.
// Build option: QFC_TRAILER_EN adds a popcount/parity trailer word to each frame.
package qubit_frame_collector_pkg;

    localparam logic [7:0] QFC_HDR_MAGIC = 8'hA5;
    localparam logic [7:0] QFC_TRL_MAGIC = 8'h5A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        TRL  = 2'd3
    } qfc_state_t;

    // Number of 32-bit data words needed to carry a frame bitmap.
    function automatic int qfc_nwords(input int num_qubits);
        return (num_qubits + 31) / 32;
    endfunction

endpackage

// File: rtl/qubit_frame_collector_word_serializer.sv
// Shadow frame register plus output word FSM.
// A completed bitmap is accepted into the shadow when it is empty, or when the
// last word of the previous frame is handed off on the same cycle. The shadow
// is then sent as a header word followed by the bitmap data words.
// Valid/ready: a word moves when o_valid && i_ready; while valid is high and
// ready is low, data/last hold steady and valid stays up until the transfer.
// Build option: QFC_TRAILER_EN appends a trailer word (popcount, parity) and moves last to it.
module qfc_word_serializer
    import qubit_frame_collector_pkg::*;
#(
    parameter int NUM_QUBITS = 100,
    parameter int WORD_W     = 32,
    parameter int SEQ_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [NUM_QUBITS-1:0] i_frame,
    input  logic                  i_ready,
    output logic                  o_accept,
    output logic [WORD_W-1:0]     o_data,
    output logic                  o_valid,
    output logic                  o_last,
    output logic [SEQ_W-1:0]      o_seq
);

    localparam int         NWORDS   = qfc_nwords(NUM_QUBITS);
    localparam int         SHADOW_W = NWORDS * WORD_W;
    localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);
    localparam logic [7:0] NQ_BYTE  = 8'(NUM_QUBITS);

    qfc_state_t          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic                full_q, full_d;
    logic [SEQ_W-1:0]    hdr_seq_q, hdr_seq_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                valid_q, valid_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                xfer, last_xfer, accept;
`ifdef QFC_TRAILER_EN
    logic [7:0]          pop_q, pop_d;
    logic                par_q, par_d;
`endif

    // Next-state: handshake advance, shadow load, and registered word decode.
    always_comb begin
        xfer      = valid_q && i_ready;
        last_xfer = xfer && last_q;
        accept    = i_load && (!full_q || last_xfer);

        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        full_d    = full_q;
        hdr_seq_d = hdr_seq_q;
        seq_d     = seq_q;
`ifdef QFC_TRAILER_EN
        pop_d     = pop_q;
        par_d     = par_q;
`endif

        if (xfer) begin
            case (state_q)
                HDR: begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
                DATA: begin
                    if (idx_q == LAST_IDX) begin
`ifdef QFC_TRAILER_EN
                        state_d = TRL;
`else
                        state_d = IDLE;
                        full_d  = 1'b0;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                TRL: begin
                    state_d = IDLE;
                    full_d  = 1'b0;
                end
                default: ;
            endcase
        end

        // A load may coincide with the final handshake; it overrides the return to IDLE.
        if (accept) begin
            full_d                   = 1'b1;
            shadow_d                 = '0;
            shadow_d[NUM_QUBITS-1:0] = i_frame;
            hdr_seq_d                = seq_q;
            seq_d                    = seq_q + 1'b1;
            state_d                  = HDR;
`ifdef QFC_TRAILER_EN
            pop_d = 8'd0;
            for (int i = 0; i < NUM_QUBITS; i++) begin
                pop_d = pop_d + {7'd0, i_frame[i]};
            end
            par_d = ^i_frame;
`endif
        end

        valid_d = (state_d != IDLE);
        data_d  = '0;
        last_d  = 1'b0;
        case (state_d)
            HDR: data_d = {QFC_HDR_MAGIC, NQ_BYTE, 16'(hdr_seq_d)};
            DATA: begin
                for (int w = 0; w < NWORDS; w++) begin
                    if (idx_d == 3'(w)) begin
                        data_d = shadow_d[w*WORD_W +: WORD_W];
                    end
                end
`ifndef QFC_TRAILER_EN
                last_d = (idx_d == LAST_IDX);
`endif
            end
`ifdef QFC_TRAILER_EN
            TRL: begin
                data_d = {QFC_TRL_MAGIC, 7'd0, par_d, 8'd0, pop_d};
                last_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Output FSM and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            shadow_q  <= '0;
            full_q    <= 1'b0;
            hdr_seq_q <= '0;
            seq_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
`ifdef QFC_TRAILER_EN
            pop_q     <= 8'd0;
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            full_q    <= full_d;
            hdr_seq_q <= hdr_seq_d;
            seq_q     <= seq_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
`ifdef QFC_TRAILER_EN
            pop_q     <= pop_d;
            par_q     <= par_d;
`endif
        end
    end

    assign o_accept = accept;
    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_last   = last_q;
    assign o_seq    = seq_q;

endmodule

// File: rtl/qubit_frame_collector.sv
// Collects 4-qubit decision groups into a NUM_QUBITS-bit frame bitmap, flags
// duplicate and malformed groups, and hands completed frames to the word
// serializer. A frame that completes while the shadow is busy is dropped.
// Build option: QFC_TRAILER_EN (trailer word, handled in the serializer).
module qubit_frame_collector
    import qubit_frame_collector_pkg::*;
#(
    parameter int NUM_QUBITS = 100,
    parameter int WORD_W     = 32,
    parameter int SEQ_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_qubit_state,
    input  logic [6:0]        i_qubit_base_id,
    input  logic              i_qubit_valid,
    output logic [31:0]       o_word_data,
    output logic              o_word_valid,
    input  logic              i_word_ready,
    output logic              o_word_last,
    output logic [SEQ_W-1:0]  o_frame_seq,
    output logic              o_overrun,
    output logic              o_dup_err,
    output logic              o_bad_id
);

    localparam int         NUM_GROUPS = NUM_QUBITS / 4;
    localparam logic [7:0] NQ_BYTE    = 8'(NUM_QUBITS);

    logic [NUM_QUBITS-1:0] bitmap_q, bitmap_d, bitmap_nx;
    logic [NUM_GROUPS-1:0] mask_q, mask_d, mask_nx;
    logic                  dup_q, dup_d;
    logic                  bad_q, bad_d;
    logic                  overrun_q, overrun_d;
    logic                  id_ok, acc, complete, ser_accept;

    // Group accept/duplicate decode; a completing frame clears the collection.
    always_comb begin
        id_ok     = (i_qubit_base_id[1:0] == 2'b00) && ({1'b0, i_qubit_base_id} < NQ_BYTE);
        bitmap_nx = bitmap_q;
        mask_nx   = mask_q;
        acc       = 1'b0;
        dup_d     = 1'b0;
        if (i_qubit_valid && id_ok) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (i_qubit_base_id[6:2] == 5'(g)) begin
                    if (mask_q[g]) begin
                        dup_d = 1'b1;
                    end else begin
                        acc              = 1'b1;
                        mask_nx[g]       = 1'b1;
                        bitmap_nx[g*4 +: 4] = i_qubit_state;
                    end
                end
            end
        end
        complete = acc && (&mask_nx);
        bitmap_d = complete ? '0 : bitmap_nx;
        mask_d   = complete ? '0 : mask_nx;
        bad_d    = i_qubit_valid && !id_ok;
    end

    // A completed frame the serializer cannot take is an overrun.
    always_comb begin
        overrun_d = complete && !ser_accept;
    end

    // Collection state and error pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bitmap_q  <= '0;
            mask_q    <= '0;
            dup_q     <= 1'b0;
            bad_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            bitmap_q  <= bitmap_d;
            mask_q    <= mask_d;
            dup_q     <= dup_d;
            bad_q     <= bad_d;
            overrun_q <= overrun_d;
        end
    end

    qfc_word_serializer #(
        .NUM_QUBITS (NUM_QUBITS),
        .WORD_W     (WORD_W),
        .SEQ_W      (SEQ_W)
    ) u_serializer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .i_load   (complete),
        .i_frame  (bitmap_nx),
        .i_ready  (i_word_ready),
        .o_accept (ser_accept),
        .o_data   (o_word_data),
        .o_valid  (o_word_valid),
        .o_last   (o_word_last),
        .o_seq    (o_frame_seq)
    );

    assign o_overrun = overrun_q;
    assign o_dup_err = dup_q;
    assign o_bad_id  = bad_q;

endmodule

// File: tb/tb_qubit_frame_collector.sv
// Directed bench for qubit_frame_collector (NUM_QUBITS=100).
module tb_qubit_frame_collector;

`ifdef QFC_TRAILER_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  q_state = 4'd0;
  logic [6:0]  q_id = 7'd0;
  logic        q_valid = 1'b0;
  logic        ready_dir = 1'b0;
  logic        rand_en = 1'b0;
  logic        rand_ready = 1'b0;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_last;
  logic [15:0] frame_seq;
  logic        overrun;
  logic        dup_err;
  logic        bad_id;

  int checks = 0;
  int failures = 0;
  int dup_cnt = 0;
  int bad_cnt = 0;
  int over_cnt = 0;
  logic        hold_pending = 1'b0;
  logic [32:0] held = '0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  assign word_ready = rand_en ? rand_ready : ready_dir;

  qubit_frame_collector #(
    .NUM_QUBITS (100),
    .WORD_W     (32),
    .SEQ_W      (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_qubit_state   (q_state),
    .i_qubit_base_id (q_id),
    .i_qubit_valid   (q_valid),
    .o_word_data     (word_data),
    .o_word_valid    (word_valid),
    .i_word_ready    (word_ready),
    .o_word_last     (word_last),
    .o_frame_seq     (frame_seq),
    .o_overrun       (overrun),
    .o_dup_err       (dup_err),
    .o_bad_id        (bad_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // random ready source for the stall test
  initial forever begin
    @(posedge clk);
    #1;
    rand_ready = ($urandom_range(0, 1) == 1);
  end

  // monitor: capture transfers, count pulses, check hold-under-stall
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (dup_err) dup_cnt++;
      if (bad_id) bad_cnt++;
      if (overrun) over_cnt++;
      if (hold_pending) begin
        check("hold_valid", {63'd0, word_valid}, 64'd1);
        check("hold_word", {31'd0, word_last, word_data}, {31'd0, held});
      end
      if (word_valid && word_ready) got_q.push_back({word_last, word_data});
      hold_pending = word_valid && !word_ready;
      held = {word_last, word_data};
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] s, input logic [6:0] id);
    q_state = s;
    q_id = id;
    q_valid = 1'b1;
    tick();
    q_valid = 1'b0;
  endtask

  task automatic send_range(input logic [3:0] s, input int first_g, input int last_g);
    for (int g = first_g; g <= last_g; g++) send(s, 7'(g * 4));
  endtask

  function automatic logic [127:0] uniform_bm(input logic [3:0] nib);
    logic [127:0] bm;
    bm = '0;
    for (int g = 0; g < 25; g++) bm[g*4 +: 4] = nib;
    return bm;
  endfunction

  // expected frame model: header, four bitmap words, optional trailer
  task automatic push_frame(input logic [15:0] seq, input logic [127:0] bm);
    logic last_data;
`ifdef QFC_TRAILER_EN
    last_data = 1'b0;
`else
    last_data = 1'b1;
`endif
    exp_q.push_back({1'b0, 8'hA5, 8'd100, seq});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) && last_data, bm[i*32 +: 32]});
`ifdef QFC_TRAILER_EN
    exp_q.push_back({1'b1, 8'h5A, 7'd0, ^bm, 8'd0, 8'($countones(bm))});
`endif
  endtask

  task automatic check_words(input string tag, input int n);
    int cyc;
    logic [32:0] g;
    logic [32:0] e;
    cyc = 0;
    while (got_q.size() < n && cyc < 400) begin
      tick();
      cyc++;
    end
    check({tag, "_count"}, 64'(got_q.size() >= n), 64'd1);
    for (int i = 0; i < n; i++) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 33'h1_DEAD_BEEF;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
      check(tag, {31'd0, g}, {31'd0, e});
    end
  endtask

  initial begin
    int lim;
    // reset state
    repeat (3) tick();
    check("rst_valid", {63'd0, word_valid}, 64'd0);
    check("rst_data", {32'd0, word_data}, 64'd0);
    check("rst_last", {63'd0, word_last}, 64'd0);
    check("rst_seq", {48'd0, frame_seq}, 64'd0);
    check("rst_pulses", {61'd0, overrun, dup_err, bad_id}, 64'd0);
    rst_n = 1'b1;
    tick();

    // frame of 25 ascending 1010 groups, ready held high
    ready_dir = 1'b1;
    send_range(4'hA, 0, 24);
    check("f1_hdr_valid", {63'd0, word_valid}, 64'd1);
    check("f1_hdr_word", {32'd0, word_data}, 64'h0000_0000_A564_0000);
    check("f1_seq", {48'd0, frame_seq}, 64'd1);
    push_frame(16'd0, uniform_bm(4'hA));
    check_words("f1_words", NW);

    // same content in scrambled order with ready toggling
    rand_en = 1'b1;
    for (int g = 0; g < 25; g++) send(4'hA, 7'(((g * 7) % 25) * 4));
    push_frame(16'd1, uniform_bm(4'hA));
    check_words("f2_words", NW);
    rand_en = 1'b0;
    check("f2_seq", {48'd0, frame_seq}, 64'd2);
    check("f2_no_errs", 64'(dup_cnt + bad_cnt + over_cnt), 64'd0);

    // second frame completes while the first is stalled
    ready_dir = 1'b0;
    send_range(4'hC, 0, 24);
    send_range(4'h5, 0, 24);
    tick();
    check("ovr_count", 64'(over_cnt), 64'd1);
    check("ovr_seq", {48'd0, frame_seq}, 64'd3);
    ready_dir = 1'b1;
    push_frame(16'd2, uniform_bm(4'hC));
    check_words("ovr_words", NW);

    // duplicate and malformed groups
    send(4'hF, 7'd8);
    send(4'h0, 7'd8);
    send(4'hF, 7'd6);
    send(4'hF, 7'd100);
    tick();
    check("dup_count", 64'(dup_cnt), 64'd1);
    check("bad_count", 64'(bad_cnt), 64'd2);
    send_range(4'h0, 0, 1);
    send_range(4'h0, 3, 23);
    check("mask_not_done", {63'd0, word_valid}, 64'd0);
    send(4'h0, 7'd96);
    check("err_frame_valid", {63'd0, word_valid}, 64'd1);
    push_frame(16'd3, 128'h0F00);
    check_words("err_words", NW);
    check("dup_after", 64'(dup_cnt), 64'd1);
    check("err_seq", {48'd0, frame_seq}, 64'd4);

    // completion lands on the last-word handshake
    ready_dir = 1'b0;
    send_range(4'h1, 0, 24);
    send_range(4'h2, 0, 23);
    ready_dir = 1'b1;
    lim = 0;
    while (!(word_valid && word_last) && lim < 20) begin
      tick();
      lim++;
    end
    check("coin_last_seen", {62'd0, word_valid, word_last}, 64'd3);
    send(4'h2, 7'd96);
    check("coin_hdr_valid", {63'd0, word_valid}, 64'd1);
    check("coin_hdr_word", {32'd0, word_data}, 64'h0000_0000_A564_0005);
    check("coin_seq", {48'd0, frame_seq}, 64'd6);
    tick();
    check("coin_no_ovr", 64'(over_cnt), 64'd1);
    push_frame(16'd4, uniform_bm(4'h1));
    push_frame(16'd5, uniform_bm(4'h2));
    check_words("coin_words", 2 * NW);

    // reset in the middle of the data words
    send_range(4'h6, 0, 24);
    tick();
    ready_dir = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, word_valid}, 64'd0);
    check("mid_rst_data", {32'd0, word_data}, 64'd0);
    check("mid_rst_last", {63'd0, word_last}, 64'd0);
    check("mid_rst_seq", {48'd0, frame_seq}, 64'd0);
    check("mid_rst_pulses", {61'd0, overrun, dup_err, bad_id}, 64'd0);
    tick();
    tick();
    got_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    ready_dir = 1'b1;
    tick();
    send_range(4'hA, 0, 24);
    check("post_rst_hdr", {32'd0, word_data}, 64'h0000_0000_A564_0000);
    check("post_rst_seq", {48'd0, frame_seq}, 64'd1);
    push_frame(16'd0, uniform_bm(4'hA));
    check_words("post_rst_words", NW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
